// File: rtl/wb_vector_regfile_if.sv
// Writeback-stage bundle: scalar writeback controls/data in, scalar RF write port out,
// vector write/read/clear controls in, bypassed vector read data and busy flag out.
interface wb_vector_regfile_if;
    logic            RegWriteW;
    logic            MemtoRegW;
    logic            linkW;
    logic [31:0]     RDW;
    logic [31:0]     ALUOutW;
    logic [31:0]     PCPlus4W;
    logic [3:0]      WA3W;
    logic            RegWriteVW;
    logic            RegWriteVVW;
    logic [8:0][8:0] ReadDataVW;
    logic [3:0]      IndexW;
    logic            ClearV;
    logic [3:0]      RA1V;
    logic [3:0]      RA2V;
    logic [31:0]     ResultW;
    logic            WE3;
    logic [3:0]      WA3;
    logic [31:0]     WD3;
    logic [8:0][8:0] RD1V;
    logic [8:0][8:0] RD2V;
    logic            BusyV;

    modport master (
        output RegWriteW, MemtoRegW, linkW, RDW, ALUOutW, PCPlus4W, WA3W,
               RegWriteVW, RegWriteVVW, ReadDataVW, IndexW, ClearV, RA1V, RA2V,
        input  ResultW, WE3, WA3, WD3, RD1V, RD2V, BusyV
    );

    modport slave (
        input  RegWriteW, MemtoRegW, linkW, RDW, ALUOutW, PCPlus4W, WA3W,
               RegWriteVW, RegWriteVVW, ReadDataVW, IndexW, ClearV, RA1V, RA2V,
        output ResultW, WE3, WA3, WD3, RD1V, RD2V, BusyV
    );
endinterface

// File: rtl/wb_vector_regfile.sv
// Writeback mux for the scalar register file plus a 16 x 9-lane x 9-bit vector register file
// with write-first read bypass and a 16-cycle background clear sequencer.
module wb_vector_regfile (
    input  logic               clk,
    input  logic               reset,
    wb_vector_regfile_if.slave bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [3:0]      ptr_q, ptr_d;
    logic [8:0][8:0] vreg_q [16];
    logic [8:0][8:0] vreg_d [16];
    logic [31:0]     result;
    logic [8:0]      wr_mask;
    logic [8:0][8:0] wr_dat;
    logic [8:0][8:0] rd1, rd2;

    assign result      = bus.MemtoRegW ? bus.RDW : bus.ALUOutW;
    assign bus.ResultW = result;
    assign bus.WE3     = bus.RegWriteW;
    assign bus.WA3     = bus.linkW ? 4'd14 : bus.WA3W;
    assign bus.WD3     = bus.linkW ? bus.PCPlus4W : result;
    assign bus.BusyV   = (state_q == S_CLEAR);
    assign bus.RD1V    = rd1;
    assign bus.RD2V    = rd2;

    // Lanes are two's-complement; a lane write just takes the low 9 result bits.
    // Out-of-range lane indices never match, so they write nothing.
    always_comb begin
        wr_mask = '0;
        wr_dat  = '0;
        for (int k = 0; k < 9; k++) begin
            wr_mask[k] = bus.RegWriteVVW | (bus.RegWriteVW & (bus.IndexW == 4'(k)));
            wr_dat[k]  = bus.RegWriteVVW ? bus.ReadDataVW[k] : result[8:0];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_IDLE) begin
            if (bus.ClearV) begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        end else begin
            ptr_d = ptr_q + 4'd1;
            if (ptr_q == 4'd15) begin
                state_d = S_IDLE;
            end
        end
    end

    // Clear first, then overlay written lanes so writeback beats the sequencer.
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            vreg_d[r] = vreg_q[r];
            if ((state_q == S_CLEAR) && (ptr_q == 4'(r))) begin
                vreg_d[r] = '0;
            end
            for (int k = 0; k < 9; k++) begin
                if ((bus.WA3W == 4'(r)) && wr_mask[k]) begin
                    vreg_d[r][k] = wr_dat[k];
                end
            end
        end
    end

    always_comb begin
        rd1 = vreg_q[bus.RA1V];
        rd2 = vreg_q[bus.RA2V];
        for (int k = 0; k < 9; k++) begin
            if ((bus.WA3W == bus.RA1V) && wr_mask[k]) begin
                rd1[k] = wr_dat[k];
            end
            if ((bus.WA3W == bus.RA2V) && wr_mask[k]) begin
                rd2[k] = wr_dat[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            for (int r = 0; r < 16; r++) begin
                vreg_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vreg_q  <= vreg_d;
        end
    end
endmodule
